// File: rtl/x_input_buffer.sv
// Operand buffer feeding the 4-lane MAC ALU: loads one ROWSxCOLS byte matrix over
// valid/ready, then replays it row by row on X_shift, PASSES times, before reloading.
module x_input_buffer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ROWS   = 8,
    parameter int unsigned COLS   = 4,
    parameter int unsigned PASSES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      X_shift,
    output logic [DATA_W:0]           X_reg1,
    output logic [DATA_W:0]           X_reg2,
    output logic [DATA_W:0]           X_reg3,
    output logic [DATA_W:0]           X_reg4,
    output logic                      buf_full,
    output logic                      buf_done,
    output logic [$clog2(ROWS)-1:0]   row_idx,
    output logic [$clog2(PASSES)-1:0] pass_idx
);

    localparam int unsigned RowW  = $clog2(ROWS);
    localparam int unsigned PassW = $clog2(PASSES);
    localparam int unsigned ColW  = $clog2(COLS);
    localparam int unsigned WrW   = $clog2(ROWS * COLS);

    localparam logic [WrW-1:0]   WrLast   = WrW'(ROWS * COLS - 1);
    localparam logic [RowW-1:0]  RowLast  = RowW'(ROWS - 1);
    localparam logic [PassW-1:0] PassLast = PassW'(PASSES - 1);

    typedef enum logic [0:0] {
        StLoad,
        StFull
    } state_e;

    state_e             state_q;
    logic [WrW-1:0]     wr_cnt_q;
    logic [RowW-1:0]    row_idx_q;
    logic [PassW-1:0]   pass_idx_q;
    logic               in_ready_q;
    logic               buf_full_q;
    logic               buf_done_q;
    logic [DATA_W-1:0]  mem_q [ROWS][COLS];
    logic               wr_en;

    // A byte only lands while loading; in_ready_q is already low in StFull.
    assign wr_en = (state_q == StLoad) && in_valid && in_ready_q;

    // Load/stream sequencer with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StLoad;
            wr_cnt_q   <= '0;
            row_idx_q  <= '0;
            pass_idx_q <= '0;
            in_ready_q <= 1'b0;
            buf_full_q <= 1'b0;
            buf_done_q <= 1'b0;
        end else begin
            buf_done_q <= 1'b0;
            unique case (state_q)
                StLoad: begin
                    in_ready_q <= 1'b1;
                    if (wr_en) begin
                        if (wr_cnt_q == WrLast) begin
                            state_q    <= StFull;
                            wr_cnt_q   <= '0;
                            in_ready_q <= 1'b0;
                            buf_full_q <= 1'b1;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + 1'b1;
                        end
                    end
                end
                StFull: begin
                    if (X_shift) begin
                        if (row_idx_q == RowLast) begin
                            row_idx_q <= '0;
                            if (pass_idx_q == PassLast) begin
                                // Last shift of last pass: free the buffer for the next load.
                                state_q    <= StLoad;
                                pass_idx_q <= '0;
                                buf_full_q <= 1'b0;
                                buf_done_q <= 1'b1;
                                in_ready_q <= 1'b1;
                            end else begin
                                pass_idx_q <= pass_idx_q + 1'b1;
                            end
                        end else begin
                            row_idx_q <= row_idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    // Matrix storage, row-major; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_cnt_q[WrW-1:ColW]][wr_cnt_q[ColW-1:0]] <= in_data;
        end
    end

    // Current row on the lanes, zero-extended; forced to zero while not full.
    always_comb begin
        X_reg1 = '0;
        X_reg2 = '0;
        X_reg3 = '0;
        X_reg4 = '0;
        if (buf_full_q) begin
            X_reg1 = {1'b0, mem_q[row_idx_q][0]};
            X_reg2 = {1'b0, mem_q[row_idx_q][1]};
            X_reg3 = {1'b0, mem_q[row_idx_q][2]};
            X_reg4 = {1'b0, mem_q[row_idx_q][3]};
        end
    end

    assign in_ready = in_ready_q;
    assign buf_full = buf_full_q;
    assign buf_done = buf_done_q;
    assign row_idx  = row_idx_q;
    assign pass_idx = pass_idx_q;

endmodule
